// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 icode/stat encodings, register IDs and reset register table.
package y86_pkg;
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;
  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;
  typedef enum logic {RUN, HALTED} wb_state_t;
  function automatic logic [63:0] reset_val(input logic [3:0] id);
    case (id)
      4'd0:    reset_val = 64'd111;
      4'd1:    reset_val = 64'd222;
      4'd2:    reset_val = 64'd333;
      4'd3:    reset_val = 64'd444;
      4'd4:    reset_val = 64'd555;
      4'd5:    reset_val = 64'd666;
      4'd6:    reset_val = -64'sd777;
      4'd7:    reset_val = 64'd888;
      4'd8:    reset_val = 64'd999;
      4'd9:    reset_val = -64'sd1111;
      4'd10:   reset_val = 64'd2222;
      4'd11:   reset_val = 64'd3333;
      4'd12:   reset_val = 64'd4444;
      4'd13:   reset_val = 64'd5555;
      4'd14:   reset_val = 64'd6666;
      default: reset_val = 64'd0;
    endcase
  endfunction
endpackage

// File: rtl/wb_dst_sel.sv
// wb_dst_sel: derives the E and M destination register IDs from the instruction.
module wb_dst_sel
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  input  logic       cnd,
  input  logic [3:0] ra,
  input  logic [3:0] rb,
  output logic [3:0] dst_e,
  output logic [3:0] dst_m
);
  always_comb begin
    dst_e = (icode == IRRMOVQ) ? (cnd ? rb : RNONE) :
            (icode == IIRMOVQ || icode == IOPQ) ? rb :
            (icode == ICALL || icode == IRET || icode == IPUSHQ || icode == IPOPQ) ? RRSP : RNONE;
    dst_m = (icode == IMRMOVQ || icode == IPOPQ) ? ra : RNONE;
  end
endmodule

// File: rtl/write_back.sv
// write_back: Y86-64 SEQ write-back stage owning the register file and retire status.
// Optional WB_RETIRE_CNT_EN adds a 64-bit count of committed instructions.
module write_back
  import y86_pkg::*;
#(
  parameter int NREG = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [3:0]  icode,
  input  logic        cnd,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic [63:0] valE,
  input  logic [63:0] valM,
  input  logic [2:0]  stat,
  output logic        in_ready,
  output logic [63:0] rax,
  output logic [63:0] rcx,
  output logic [63:0] rdx,
  output logic [63:0] rbx,
  output logic [63:0] rsp,
  output logic [63:0] rbp,
  output logic [63:0] rsi,
  output logic [63:0] rdi,
  output logic [63:0] r8,
  output logic [63:0] r9,
  output logic [63:0] r10,
  output logic [63:0] r11,
  output logic [63:0] r12,
  output logic [63:0] r13,
  output logic [63:0] r14,
  output logic        halted,
  output logic [2:0]  wb_stat
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0] retired_cnt
`endif
);
  wb_state_t state, state_d;
  logic [63:0] regs [15];
  logic [3:0] dst_e, dst_m;
  logic accept, commit, we_e, we_m;
  wb_dst_sel u_dst_sel (
    .icode(icode),
    .cnd(cnd),
    .ra(rA),
    .rb(rB),
    .dst_e(dst_e),
    .dst_m(dst_m)
  );
  always_comb begin
    accept  = instr_valid && state == RUN;
    commit  = accept && stat == SAOK;
    we_e    = commit && dst_e != RNONE && int'(dst_e) < NREG;
    we_m    = commit && dst_m != RNONE && int'(dst_m) < NREG;
    state_d = (accept && stat != SAOK) ? HALTED : state;
  end
  always_ff @(posedge clk)
    if (rst) state <= RUN;
    else state <= state_d;
  // M port is written second so popq %rsp leaves valM in rsp
  always_ff @(posedge clk)
    if (rst) begin
      for (int i = 0; i < 15; i++) regs[i] <= reset_val(4'(i));
    end else begin
      if (we_e) regs[dst_e] <= valE;
      if (we_m) regs[dst_m] <= valM;
    end
  always_ff @(posedge clk)
    if (rst) wb_stat <= SAOK;
    else if (accept) wb_stat <= stat;
`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clk)
    if (rst) retired_cnt <= '0;
    else if (commit) retired_cnt <= retired_cnt + 64'd1;
`endif
  assign in_ready = state == RUN;
  assign halted   = state == HALTED;
  assign rax = regs[0];
  assign rcx = regs[1];
  assign rdx = regs[2];
  assign rbx = regs[3];
  assign rsp = regs[4];
  assign rbp = regs[5];
  assign rsi = regs[6];
  assign rdi = regs[7];
  assign r8  = regs[8];
  assign r9  = regs[9];
  assign r10 = regs[10];
  assign r11 = regs[11];
  assign r12 = regs[12];
  assign r13 = regs[13];
  assign r14 = regs[14];
endmodule

// File: tb/tb_write_back.sv
// tb_write_back: vector table + scoreboard bench for write_back (WB_RETIRE_CNT_EN optional).
module tb_write_back;
  logic clk = 1'b0;
  logic rst, instr_valid, cnd;
  logic [3:0] icode, ra, rb;
  logic [63:0] vale, valm;
  logic [2:0] stat;
  logic in_ready, halted;
  logic [2:0] wb_stat;
  logic [63:0] r [15];
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retired_cnt;
`endif
  write_back dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .icode(icode), .cnd(cnd),
    .rA(ra), .rB(rb), .valE(vale), .valM(valm), .stat(stat), .in_ready(in_ready),
    .rax(r[0]), .rcx(r[1]), .rdx(r[2]), .rbx(r[3]), .rsp(r[4]), .rbp(r[5]),
    .rsi(r[6]), .rdi(r[7]), .r8(r[8]), .r9(r[9]), .r10(r[10]), .r11(r[11]),
    .r12(r[12]), .r13(r[13]), .r14(r[14]), .halted(halted), .wb_stat(wb_stat)
`ifdef WB_RETIRE_CNT_EN
    , .retired_cnt(retired_cnt)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        v;
    logic [3:0]  ic;
    logic        c;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [63:0] ve;
    logic [63:0] vm;
    logic [2:0]  st;
    logic        w1;
    logic [3:0]  i1;
    logic [63:0] v1;
    logic        w2;
    logic [3:0]  i2;
    logic [63:0] v2;
    logic        hlt;
    logic [2:0]  ws;
  } vec_t;
  vec_t vecs[$];
  vec_t exp_q[$];
  logic [63:0] rst_tab [15] = '{64'd111, 64'd222, 64'd333, 64'd444, 64'd555, 64'd666,
    64'hFFFF_FFFF_FFFF_FCF7, 64'd888, 64'd999, 64'hFFFF_FFFF_FFFF_FBA9, 64'd2222,
    64'd3333, 64'd4444, 64'd5555, 64'd6666};
  logic [63:0] shadow [15];
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic exp_h, input logic [2:0] exp_ws);
    for (int i = 0; i < 15; i++) chk($sformatf("%s r%0d", tag, i), r[i], shadow[i]);
    chk({tag, " halted"}, 64'(halted), 64'(exp_h));
    chk({tag, " in_ready"}, 64'(in_ready), 64'(!exp_h));
    chk({tag, " wb_stat"}, 64'(wb_stat), 64'(exp_ws));
  endtask
  task automatic drive(input logic v, input logic [3:0] ic, input logic c, input logic [3:0] a,
                       input logic [3:0] b, input logic [63:0] ve, input logic [63:0] vm,
                       input logic [2:0] st);
    instr_valid = v; icode = ic; cnd = c; ra = a; rb = b; vale = ve; valm = vm; stat = st;
  endtask
  initial begin
    vec_t e;
    vecs.push_back('{1'b0, 4'h0, 1'b0, 4'hF, 4'hF, 64'd0, 64'd0, 3'd1, 1'b0, 4'd0, 64'd0, 1'b0, 4'd0, 64'd0, 1'b0, 3'd1});
    vecs.push_back('{1'b1, 4'h6, 1'b0, 4'hF, 4'h2, 64'h1234, 64'd0, 3'd1, 1'b1, 4'd2, 64'h1234, 1'b0, 4'd0, 64'd0, 1'b0, 3'd1});
    vecs.push_back('{1'b1, 4'h2, 1'b0, 4'hF, 4'h3, 64'd7, 64'd0, 3'd1, 1'b0, 4'd0, 64'd0, 1'b0, 4'd0, 64'd0, 1'b0, 3'd1});
    vecs.push_back('{1'b1, 4'h2, 1'b1, 4'hF, 4'h3, 64'd7, 64'd0, 3'd1, 1'b1, 4'd3, 64'd7, 1'b0, 4'd0, 64'd0, 1'b0, 3'd1});
    vecs.push_back('{1'b1, 4'hB, 1'b0, 4'h4, 4'hF, 64'd563, 64'hABC, 3'd1, 1'b1, 4'd4, 64'hABC, 1'b0, 4'd0, 64'd0, 1'b0, 3'd1});
    vecs.push_back('{1'b1, 4'hB, 1'b0, 4'h0, 4'hF, 64'd563, 64'hABC, 3'd1, 1'b1, 4'd4, 64'd563, 1'b1, 4'd0, 64'hABC, 1'b0, 3'd1});
    vecs.push_back('{1'b1, 4'h3, 1'b0, 4'hF, 4'h6, 64'h55, 64'd0, 3'd1, 1'b1, 4'd6, 64'h55, 1'b0, 4'd0, 64'd0, 1'b0, 3'd1});
    vecs.push_back('{1'b1, 4'hA, 1'b0, 4'h2, 4'hF, 64'd100, 64'd0, 3'd1, 1'b1, 4'd4, 64'd100, 1'b0, 4'd0, 64'd0, 1'b0, 3'd1});
    vecs.push_back('{1'b1, 4'h8, 1'b0, 4'hF, 4'hF, 64'd200, 64'd0, 3'd1, 1'b1, 4'd4, 64'd200, 1'b0, 4'd0, 64'd0, 1'b0, 3'd1});
    vecs.push_back('{1'b1, 4'h9, 1'b0, 4'hF, 4'hF, 64'd208, 64'd77, 3'd1, 1'b1, 4'd4, 64'd208, 1'b0, 4'd0, 64'd0, 1'b0, 3'd1});
    vecs.push_back('{1'b1, 4'h4, 1'b0, 4'h1, 4'h2, 64'd999999, 64'd5, 3'd1, 1'b0, 4'd0, 64'd0, 1'b0, 4'd0, 64'd0, 1'b0, 3'd1});
    vecs.push_back('{1'b1, 4'h3, 1'b0, 4'hF, 4'hF, 64'd123, 64'd0, 3'd1, 1'b0, 4'd0, 64'd0, 1'b0, 4'd0, 64'd0, 1'b0, 3'd1});
    vecs.push_back('{1'b1, 4'h6, 1'b0, 4'hF, 4'hE, '1, 64'd0, 3'd1, 1'b1, 4'd14, '1, 1'b0, 4'd0, 64'd0, 1'b0, 3'd1});
    vecs.push_back('{1'b1, 4'h5, 1'b0, 4'h7, 4'hF, 64'd0, 64'd321, 3'd1, 1'b1, 4'd7, 64'd321, 1'b0, 4'd0, 64'd0, 1'b0, 3'd1});
    vecs.push_back('{1'b1, 4'h5, 1'b0, 4'h1, 4'hF, 64'd0, 64'd9, 3'd3, 1'b0, 4'd0, 64'd0, 1'b0, 4'd0, 64'd0, 1'b1, 3'd3});
    vecs.push_back('{1'b1, 4'h3, 1'b0, 4'hF, 4'h2, 64'd99, 64'd0, 3'd1, 1'b0, 4'd0, 64'd0, 1'b0, 4'd0, 64'd0, 1'b1, 3'd3});
    vecs.push_back('{1'b1, 4'hB, 1'b0, 4'h0, 4'hF, 64'd1, 64'd2, 3'd2, 1'b0, 4'd0, 64'd0, 1'b0, 4'd0, 64'd0, 1'b1, 3'd3});
    rst = 1'b1;
    drive(1'b0, 4'h0, 1'b0, 4'hF, 4'hF, 64'd0, 64'd0, 3'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 15; i++) shadow[i] = rst_tab[i];
    chk_all("reset", 1'b0, 3'd1);
`ifdef WB_RETIRE_CNT_EN
    chk("reset cnt", retired_cnt, 64'd0);
`endif
    foreach (vecs[k]) begin
      drive(vecs[k].v, vecs[k].ic, vecs[k].c, vecs[k].a, vecs[k].b, vecs[k].ve, vecs[k].vm, vecs[k].st);
      exp_q.push_back(vecs[k]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      if (e.w1) shadow[e.i1] = e.v1;
      if (e.w2) shadow[e.i2] = e.v2;
      chk_all($sformatf("vec%0d", k), e.hlt, e.ws);
    end
    rst = 1'b1;
    drive(1'b1, 4'h6, 1'b0, 4'hF, 4'h0, 64'd1, 64'd0, 3'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1'b0, 4'h0, 1'b0, 4'hF, 4'hF, 64'd0, 64'd0, 3'd1);
    for (int i = 0; i < 15; i++) shadow[i] = rst_tab[i];
    chk_all("rst_over_commit", 1'b0, 3'd1);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 4'h6, 1'b0, 4'hF, 4'h8, 64'(k + 40), 64'd0, 3'd1);
      @(posedge clk);
      #1;
      chk($sformatf("b2b r8 %0d", k), r[8], 64'(k + 40));
    end
    drive(1'b0, 4'h0, 1'b0, 4'hF, 4'hF, 64'd0, 64'd0, 3'd1);
    @(posedge clk);
    #1;
    shadow[8] = 64'd42;
    chk_all("after_b2b", 1'b0, 3'd1);
`ifdef WB_RETIRE_CNT_EN
    chk("cnt after 3", retired_cnt, 64'd3);
    drive(1'b1, 4'h1, 1'b0, 4'hF, 4'hF, 64'd0, 64'd0, 3'd4);
    @(posedge clk);
    #1;
    drive(1'b1, 4'h1, 1'b0, 4'hF, 4'hF, 64'd0, 64'd0, 3'd1);
    @(posedge clk);
    #1;
    chk("cnt frozen", retired_cnt, 64'd3);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
